// File: rtl/dna_syndrome_calc.sv
// Streaming syndrome front end: collects N received quaternary symbols and accumulates word_sum / inv_syn.
// Latency: out_valid rises on the edge that accepts the in_last symbol, then holds until out_ready.
// Backpressure: in_ready drops while a result is waiting; outputs are frozen until out_ready.
// Optional: define DNA_SYM_SUM_EN to add the sym_sum output (sum of received symbols mod 4).
module dna_syndrome_calc #(
    parameter int N = 98
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_sym,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] word_out,
    output logic [8:0]     word_sum,
    output logic [13:0]    inv_syn,
`ifdef DNA_SYM_SUM_EN
    output logic [1:0]     sym_sum,
`endif
    output logic           len_err
);

    localparam int M  = 4 * (N + 1);
    localparam int CW = $clog2(N + 1);
    localparam int AW = 16;

    typedef enum logic {COLLECT, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [1:0]      prev;
    logic [13:0]     acc;
    logic [1:0]      d;
    logic [AW-1:0]   acc_sum;
    logic [13:0]     acc_next;
    logic            room;
    logic            xfer;
    logic            short_word;

    assign in_ready = (state == COLLECT);
    assign inv_syn  = acc;
    assign xfer     = in_valid && (state == COLLECT);
    assign room     = (AW'(count) < AW'(N));

    // Differential symbol and the modular weighted-syndrome update; weight i is count+1.
    always_comb begin
        d          = in_sym - prev;
        acc_sum    = AW'(acc) + (AW'(count) + AW'(1)) * AW'(d);
        acc_next   = (acc_sum >= AW'(M)) ? 14'(acc_sum - AW'(M)) : 14'(acc_sum);
        short_word = (AW'(count) + AW'(1)) != AW'(N);
    end

    // Collect/hold FSM with all datapath registers; a handshake in DONE clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            count     <= '0;
            prev      <= '0;
            acc       <= '0;
            word_out  <= '0;
            word_sum  <= '0;
            out_valid <= 1'b0;
            len_err   <= 1'b0;
`ifdef DNA_SYM_SUM_EN
            sym_sum   <= '0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (xfer) begin
                        if (room) begin
                            word_out <= word_out | ((2*N)'(in_sym) << {count, 1'b0});
                            word_sum <= word_sum + 9'(d);
                            acc      <= acc_next;
                            prev     <= in_sym;
                            count    <= count + 1'b1;
`ifdef DNA_SYM_SUM_EN
                            sym_sum  <= sym_sum + in_sym;
`endif
                            // Final symbol of a word that is too short.
                            if (in_last && short_word)
                                len_err <= 1'b1;
                        end else begin
                            // Symbol beyond slot N: dropped, word is too long.
                            len_err <= 1'b1;
                        end
                        if (in_last) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= COLLECT;
                        out_valid <= 1'b0;
                        count     <= '0;
                        prev      <= '0;
                        acc       <= '0;
                        word_out  <= '0;
                        word_sum  <= '0;
                        len_err   <= 1'b0;
`ifdef DNA_SYM_SUM_EN
                        sym_sum   <= '0;
`endif
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
